// File: rtl/data_memory_mmio.sv
// Data-side responder for the single-cycle RV32I core: word RAM plus GPIO/timer/status register bank.
// The timer block (TCOUNT, TCMP, CTRL, STATUS[0], timer_irq) is built only when DMEM_TIMER_EN is defined.
module data_memory_mmio #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_addr,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic [7:0]  gpio_out,
  output logic        timer_irq,
  output logic        mem_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [2:0] OFF_GPIO   = 3'd0;
  localparam logic [2:0] OFF_TCOUNT = 3'd1;
  localparam logic [2:0] OFF_TCMP   = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;

  logic [31:0]      ram [DEPTH_WORDS];
  logic [IDX_W-1:0] ram_idx;
  logic [2:0]       reg_off;
  logic             aligned;
  logic             in_ram;
  logic             in_mmio;
  logic             store_ok;
  logic             bad_store;
  logic             ram_we;
  logic             mmio_we;
  logic             gpio_we;
  logic             status_we;

  logic [7:0]       gpio_q;
  logic             bad_q;
  logic             match_flag;

  assign aligned  = (data_addr[1:0] == 2'b00);
  assign in_ram   = (data_addr[31:IDX_W+2] == '0);
  assign in_mmio  = (data_addr[31:5] == MMIO_BASE[31:5]);
  assign ram_idx  = data_addr[IDX_W+1:2];
  assign reg_off  = data_addr[4:2];

  // Timer offsets count as known even when the timer is absent, so stores there never flag.
  assign store_ok  = aligned &&
                     (in_ram || (in_mmio && (reg_off inside {OFF_GPIO, OFF_TCOUNT, OFF_TCMP,
                                                             OFF_STATUS, OFF_CTRL})));
  assign bad_store = mem_write && !store_ok;

  assign ram_we    = reset && mem_write && aligned && in_ram;
  assign mmio_we   = mem_write && aligned && in_mmio && !in_ram;
  assign gpio_we   = mmio_we && (reg_off == OFF_GPIO);
  assign status_we = mmio_we && (reg_off == OFF_STATUS);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gpio_q <= '0;
      bad_q  <= 1'b0;
    end else begin
      if (gpio_we) begin
        gpio_q <= write_data[7:0];
      end
      if (bad_store) begin
        bad_q <= 1'b1;
      end else if (status_we && write_data[1]) begin
        bad_q <= 1'b0;
      end
    end
  end

`ifdef DMEM_TIMER_EN
  logic [31:0] tcount_q;
  logic [31:0] tcmp_q;
  logic [2:0]  ctrl_q;
  logic        match_q;
  logic        timer_hit;
  logic        tcount_we;
  logic        tcmp_we;
  logic        ctrl_we;

  assign tcount_we = mmio_we && (reg_off == OFF_TCOUNT);
  assign tcmp_we   = mmio_we && (reg_off == OFF_TCMP);
  assign ctrl_we   = mmio_we && (reg_off == OFF_CTRL);
  assign timer_hit = ctrl_q[0] && (tcount_q == tcmp_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      tcount_q <= '0;
      tcmp_q   <= '0;
      ctrl_q   <= '0;
      match_q  <= 1'b0;
    end else begin
      // A software write to TCOUNT beats both increment and auto-clear.
      if (tcount_we) begin
        tcount_q <= write_data;
      end else if (ctrl_q[0]) begin
        tcount_q <= (timer_hit && ctrl_q[1]) ? 32'd0 : tcount_q + 32'd1;
      end
      if (tcmp_we) begin
        tcmp_q <= write_data;
      end
      if (ctrl_we) begin
        ctrl_q <= write_data[2:0];
      end
      if (timer_hit) begin
        match_q <= 1'b1;
      end else if (status_we && write_data[0]) begin
        match_q <= 1'b0;
      end
    end
  end

  assign match_flag = match_q;
  assign timer_irq  = match_q & ctrl_q[2];
`else
  logic unused_wdata;
  assign unused_wdata = ^write_data[31:8];
  assign match_flag   = 1'b0;
  assign timer_irq    = 1'b0;
`endif

  always_comb begin
    read_data = '0;
    if (aligned) begin
      if (in_ram) begin
        read_data = ram[ram_idx];
      end else if (in_mmio) begin
        case (reg_off)
          OFF_GPIO:   read_data = {24'd0, gpio_q};
          OFF_STATUS: read_data = {30'd0, bad_q, match_flag};
`ifdef DMEM_TIMER_EN
          OFF_TCOUNT: read_data = tcount_q;
          OFF_TCMP:   read_data = tcmp_q;
          OFF_CTRL:   read_data = {29'd0, ctrl_q};
`endif
          default:    read_data = '0;
        endcase
      end
    end
  end

  assign gpio_out = gpio_q;
  assign mem_err  = bad_q;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed self-checking bench for data_memory_mmio; timer steps are compiled in with DMEM_TIMER_EN.
module tb_data_memory_mmio;
  localparam logic [31:0] M = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic        mem_write;
  logic [31:0] read_data;
  logic [7:0]  gpio_out;
  logic        timer_irq;
  logic        mem_err;

  int checks;
  int failures;

  data_memory_mmio #(.DEPTH_WORDS(256), .MMIO_BASE(M)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_addr  (data_addr),
    .write_data (write_data),
    .mem_write  (mem_write),
    .read_data  (read_data),
    .gpio_out   (gpio_out),
    .timer_irq  (timer_irq),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    data_addr  = a;
    write_data = d;
    mem_write  = 1'b1;
    @(posedge clk);
    #1;
    mem_write  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    data_addr = a;
    mem_write = 1'b0;
    #1;
    chk(tag, read_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    mem_write  = 1'b0;
    data_addr  = '0;
    write_data = '0;
    tick();
    tick();
    reset = 1'b1;

    chk("rst_gpio", 32'(gpio_out), 32'h0);
    chk("rst_irq", 32'(timer_irq), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    rd("rst_status", M + 32'h0C, 32'h0);

    wr(32'h14, 32'h1111_1111);
    wr(32'h10, 32'hDEAD_BEEF);
    rd("ram_10", 32'h10, 32'hDEAD_BEEF);
    rd("ram_14", 32'h14, 32'h1111_1111);
    chk("ram_noerr", 32'(mem_err), 32'h0);

    wr(32'h11, 32'h0000_1234);
    chk("misal_err", 32'(mem_err), 32'h1);
    rd("misal_ram_kept", 32'h10, 32'hDEAD_BEEF);
    rd("misal_read0", 32'h11, 32'h0);
    rd("status_bad", M + 32'h0C, 32'h2);

    wr(M + 32'h0C, 32'h2);
    chk("w1c_err", 32'(mem_err), 32'h0);
    rd("w1c_status", M + 32'h0C, 32'h0);

    data_addr = 32'h13;
    tick();
    data_addr = 32'h8000;
    tick();
    chk("read_no_err", 32'(mem_err), 32'h0);

    wr(32'h8000, 32'hCAFE_F00D);
    chk("unmapped_err", 32'(mem_err), 32'h1);
    rd("unmapped_read0", 32'h8000, 32'h0);
    wr(M + 32'h0C, 32'h2);

    wr(32'h3FC, 32'h0BAD_F00D);
    rd("ram_top", 32'h3FC, 32'h0BAD_F00D);
    chk("ram_top_noerr", 32'(mem_err), 32'h0);
    wr(32'h400, 32'h1);
    chk("ram_end_err", 32'(mem_err), 32'h1);
    wr(M + 32'h0C, 32'h2);

    wr(M, 32'hFFFF_FFA5);
    chk("gpio_out", 32'(gpio_out), 32'hA5);
    rd("gpio_read", M, 32'h0000_00A5);
    chk("gpio_noerr", 32'(mem_err), 32'h0);

    wr(M + 32'h14, 32'hFF);
    chk("unused_off_err", 32'(mem_err), 32'h1);
    rd("unused_off_read0", M + 32'h14, 32'h0);
    wr(M + 32'h0C, 32'h2);
    wr(M + 32'h1, 32'h33);
    chk("mmio_misal_err", 32'(mem_err), 32'h1);
    chk("mmio_misal_gpio", 32'(gpio_out), 32'hA5);
    wr(M + 32'h0C, 32'h2);

`ifdef DMEM_TIMER_EN
    wr(M + 32'h0C, 32'h3);
    wr(M + 32'h04, 32'h0);
    wr(M + 32'h08, 32'h5);
    wr(M + 32'h10, 32'h7);
    rd("tcnt_start", M + 32'h04, 32'h0);
    repeat (5) tick();
    rd("tcnt_5", M + 32'h04, 32'h5);
    chk("irq_pre", 32'(timer_irq), 32'h0);
    rd("status_pre", M + 32'h0C, 32'h0);
    tick();
    chk("irq_match", 32'(timer_irq), 32'h1);
    rd("status_match", M + 32'h0C, 32'h1);
    rd("tcnt_autoclr", M + 32'h04, 32'h0);
    wr(M + 32'h0C, 32'h1);
    chk("irq_cleared", 32'(timer_irq), 32'h0);
    rd("status_cleared", M + 32'h0C, 32'h0);

    wr(M + 32'h10, 32'h0);
    wr(M + 32'h04, 32'hFFFF_FFFF);
    wr(M + 32'h10, 32'h1);
    rd("tcnt_max", M + 32'h04, 32'hFFFF_FFFF);
    tick();
    rd("tcnt_wrap", M + 32'h04, 32'h0);
    rd("wrap_no_match", M + 32'h0C, 32'h0);

    wr(M + 32'h10, 32'h0);
    wr(M + 32'h04, 32'h5);
    wr(M + 32'h10, 32'h3);
    wr(M + 32'h04, 32'd100);
    rd("tcnt_sw_wins", M + 32'h04, 32'd100);
    rd("match_on_write", M + 32'h0C, 32'h1);

    wr(M + 32'h10, 32'h0);
    wr(M + 32'h0C, 32'h1);
    wr(M + 32'h04, 32'h5);
    wr(M + 32'h10, 32'h1);
    rd("status_before_w1c", M + 32'h0C, 32'h0);
    wr(M + 32'h0C, 32'h1);
    rd("set_beats_w1c", M + 32'h0C, 32'h1);
    chk("irq_gated", 32'(timer_irq), 32'h0);
    wr(M + 32'h10, 32'h0);
    wr(M + 32'h0C, 32'h1);
`else
    wr(M + 32'h04, 32'h55);
    wr(M + 32'h08, 32'h66);
    wr(M + 32'h10, 32'h7);
    chk("notimer_noerr", 32'(mem_err), 32'h0);
    rd("notimer_tcnt0", M + 32'h04, 32'h0);
    rd("notimer_ctrl0", M + 32'h10, 32'h0);
    chk("notimer_irq", 32'(timer_irq), 32'h0);
`endif

    wr(M, 32'h5A);
    wr(32'h8000, 32'h0);
`ifdef DMEM_TIMER_EN
    wr(M + 32'h08, 32'h3);
    wr(M + 32'h04, 32'h0);
    wr(M + 32'h10, 32'h7);
    repeat (5) tick();
    chk("pre_rst_irq", 32'(timer_irq), 32'h1);
    rd("pre_rst_tcnt", M + 32'h04, 32'h1);
`endif
    chk("pre_rst_err", 32'(mem_err), 32'h1);
    chk("pre_rst_gpio", 32'(gpio_out), 32'h5A);

    data_addr  = M;
    write_data = 32'hFF;
    mem_write  = 1'b1;
    reset      = 1'b0;
    @(posedge clk);
    #1;
    reset     = 1'b1;
    mem_write = 1'b0;
    chk("mid_rst_gpio", 32'(gpio_out), 32'h0);
    chk("mid_rst_irq", 32'(timer_irq), 32'h0);
    chk("mid_rst_err", 32'(mem_err), 32'h0);
    rd("mid_rst_tcnt", M + 32'h04, 32'h0);
    rd("mid_rst_ctrl", M + 32'h10, 32'h0);
    rd("mid_rst_ram", 32'h10, 32'hDEAD_BEEF);
    tick();
    rd("post_rst_tcnt", M + 32'h04, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
